// File: rtl/unsigned_product_accumulator_if.sv
// ---------------------------------------------------------------------------
// unsigned_product_accumulator_if
//
// Bundles the input (product) handshake and the output (result) handshake of
// unsigned_product_accumulator.
//
// Handshake rule, used on both sides: a transfer happens on a rising clk edge
// where valid and ready are both 1. The source holds its payload stable while
// valid=1 and ready=0. The block's in_ready may depend combinationally on
// out_ready, but never on in_valid.
//
// Signals
//   z         16      unsigned 8x8 product offered to the block
//   in_valid  1       z is valid this cycle
//   in_last   1       z is the final product of its group
//   in_ready  1       block accepts z this cycle
//   acc       ACC_W   accumulated group sum
//   count     8       number of products in the group
//   sat       1       group sum saturated
//   out_valid 1       acc/count/sat hold a completed result
//   out_ready 1       downstream accepts the result
//
// Modports
//   master  the traffic source/sink around the block (drives z, in_valid,
//           in_last, out_ready)
//   slave   the accumulator itself
// ---------------------------------------------------------------------------
interface unsigned_product_accumulator_if #(
    parameter int ACC_W = 24
);
    logic [15:0]      z;
    logic             in_valid;
    logic             in_last;
    logic             in_ready;
    logic [ACC_W-1:0] acc;
    logic [7:0]       count;
    logic             sat;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output z, in_valid, in_last, out_ready,
        input  in_ready, acc, count, sat, out_valid
    );

    modport slave (
        input  z, in_valid, in_last, out_ready,
        output in_ready, acc, count, sat, out_valid
    );
endinterface

// File: rtl/unsigned_product_accumulator.sv
// ---------------------------------------------------------------------------
// unsigned_product_accumulator
//
// Sums groups of unsigned 16-bit products into a saturating ACC_W-bit
// accumulator. A group ends when a product arrives with in_last=1 or when
// LEN products have been summed. The completed sum, product count and
// saturation flag are then held until the downstream side consumes them.
// A new group may begin on the same edge that consumes the previous result,
// so back-to-back groups need no idle cycle.
//
// Parameters
//   LEN    products per group, 1..255
//   ACC_W  accumulator width, 17..32
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   bus          unsigned_product_accumulator_if.slave (both handshakes)
//   dbg_state_o  current FSM state (IDLE=0, ACC=1, HOLD=2)
//
// States
//   IDLE  no group open; accepts the first product of a group
//   ACC   group open; adds each accepted product
//   HOLD  result pending; in_ready follows out_ready
// ---------------------------------------------------------------------------
module unsigned_product_accumulator #(
    parameter int LEN   = 8,
    parameter int ACC_W = 24
) (
    input  logic                           clk,
    input  logic                           rst_n,
    unsigned_product_accumulator_if.slave  bus,
    output logic [1:0]                     dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    localparam logic [ACC_W-1:0] ACC_MAX = {ACC_W{1'b1}};
    localparam logic [7:0]       LEN_C   = 8'(LEN);

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [7:0]       count_q, count_d;
    logic             sat_q, sat_d;
    logic             out_valid_q, out_valid_d;

    logic             in_ready_w;
    logic             accept_w;
    logic             consume_w;
    logic             start_w;
    logic [ACC_W:0]   sum_w;
    logic [ACC_W-1:0] z_ext_w;
    logic [7:0]       count_inc_w;

    // In HOLD the slot frees exactly when the pending result leaves, so the
    // input side may only advance on an edge that also consumes the output.
    assign in_ready_w  = (state_q != S_HOLD) | bus.out_ready;
    assign accept_w    = bus.in_valid & in_ready_w;
    assign consume_w   = out_valid_q & bus.out_ready;

    // Any accept outside ACC opens a fresh group (IDLE, or HOLD with a
    // simultaneous consume).
    assign start_w     = accept_w & (state_q != S_ACC);

    assign z_ext_w     = {{(ACC_W-16){1'b0}}, bus.z};
    // One extra bit catches the carry that marks overflow.
    assign sum_w       = {1'b0, acc_q} + {1'b0, z_ext_w};
    assign count_inc_w = count_q + 8'd1;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        count_d     = count_q;
        sat_d       = sat_q;
        out_valid_d = out_valid_q;

        case (state_q)
            S_IDLE: begin
                // Only the group start below applies here.
            end

            S_ACC: begin
                if (accept_w) begin
                    acc_d   = sum_w[ACC_W] ? ACC_MAX : sum_w[ACC_W-1:0];
                    sat_d   = sat_q | sum_w[ACC_W];
                    count_d = count_inc_w;
                    if (bus.in_last || (count_inc_w == LEN_C)) begin
                        state_d     = S_HOLD;
                        out_valid_d = 1'b1;
                    end
                end
            end

            S_HOLD: begin
                // Result registers are left untouched so they stay stable
                // under backpressure and remain visible after a consume.
                if (consume_w) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                end
            end

            default: begin
                state_d     = S_IDLE;
                out_valid_d = 1'b0;
            end
        endcase

        // Group start overrides the HOLD->IDLE move when both happen.
        if (start_w) begin
            acc_d   = z_ext_w;
            count_d = 8'd1;
            sat_d   = 1'b0;
            if (bus.in_last || (LEN == 1)) begin
                state_d     = S_HOLD;
                out_valid_d = 1'b1;
            end else begin
                state_d     = S_ACC;
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            count_q     <= '0;
            sat_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            sat_q       <= sat_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready_w;
    assign bus.acc       = acc_q;
    assign bus.count     = count_q;
    assign bus.sat       = sat_q;
    assign bus.out_valid = out_valid_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_unsigned_product_accumulator.sv
// Two accumulators share one stimulus stream: "a" (LEN=4, ACC_W=24) and
// "b" (LEN=3, ACC_W=17). Each has its own reference model and result queue.
module tb_unsigned_product_accumulator;
  localparam int unsigned LEN_A  = 4;
  localparam int unsigned ACCW_A = 24;
  localparam int unsigned LEN_B  = 3;
  localparam int unsigned ACCW_B = 17;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] z_s    = '0;
  logic        v_s    = 1'b0;
  logic        last_s = 1'b0;
  logic        ordy_s = 1'b0;
  logic [1:0]  dbg_a, dbg_b;

  unsigned_product_accumulator_if #(.ACC_W(ACCW_A)) ifa ();
  unsigned_product_accumulator_if #(.ACC_W(ACCW_B)) ifb ();

  assign ifa.z = z_s;  assign ifa.in_valid = v_s;  assign ifa.in_last = last_s;  assign ifa.out_ready = ordy_s;
  assign ifb.z = z_s;  assign ifb.in_valid = v_s;  assign ifb.in_last = last_s;  assign ifb.out_ready = ordy_s;

  unsigned_product_accumulator #(.LEN(LEN_A), .ACC_W(ACCW_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa), .dbg_state_o(dbg_a)
  );
  unsigned_product_accumulator #(.LEN(LEN_B), .ACC_W(ACCW_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb), .dbg_state_o(dbg_b)
  );

  // ---------------- scoreboard ----------------
  typedef struct {
    bit              hold;
    bit              grp;
    int unsigned     cnt;
    longint unsigned acc;
    bit              sat;
  } mdl_t;

  mdl_t        ma, mb;
  logic [40:0] exp_qa[$];
  logic [40:0] exp_qb[$];
  int          n_checks = 0;
  int          n_err    = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [40:0] pack(input longint unsigned acc, input int unsigned cnt, input bit sat);
    logic [31:0] a32;
    logic [7:0]  c8;
    a32 = acc[31:0];
    c8  = cnt[7:0];
    return {sat, c8, a32};
  endfunction

  // Compare one DUT against its model, then advance the model across the
  // coming edge using the inputs now on the bus.
  task automatic check_side(input int s, input logic ir, input logic ov,
                            input logic [31:0] acc, input logic [7:0] cnt, input logic st);
    mdl_t            m;
    int unsigned     len;
    longint unsigned amax;
    string           nm;
    logic [40:0]     front;
    int              depth;
    bit              acc_e;
    m    = (s != 0) ? mb : ma;
    len  = (s != 0) ? LEN_B : LEN_A;
    amax = (64'd1 << ((s != 0) ? ACCW_B : ACCW_A)) - 64'd1;
    nm   = (s != 0) ? "b" : "a";

    check_val({nm, "_in_ready"}, 64'(ir), 64'(!m.hold || ordy_s));
    check_val({nm, "_out_valid"}, 64'(ov), 64'(m.hold));
    if (ov) begin
      depth = (s != 0) ? exp_qb.size() : exp_qa.size();
      if (depth == 0) begin
        check_val({nm, "_q_depth"}, 64'(depth), 64'd1);
      end else begin
        front = (s != 0) ? exp_qb[0] : exp_qa[0];
        check_val({nm, "_result"}, 64'({st, cnt, acc}), 64'(front));
        if (ordy_s) begin
          if (s != 0) void'(exp_qb.pop_front());
          else        void'(exp_qa.pop_front());
        end
      end
    end

    acc_e = v_s && (!m.hold || ordy_s);
    if (m.hold && ordy_s) m.hold = 1'b0;
    if (acc_e) begin
      if (!m.grp) begin
        m.acc = 64'(z_s);
        m.cnt = 1;
        m.sat = 1'b0;
      end else begin
        m.acc = m.acc + 64'(z_s);
        if (m.acc > amax) begin
          m.acc = amax;
          m.sat = 1'b1;
        end
        m.cnt = m.cnt + 1;
      end
      if (last_s || m.cnt == len) begin
        m.hold = 1'b1;
        m.grp  = 1'b0;
        if (s != 0) exp_qb.push_back(pack(m.acc, m.cnt, m.sat));
        else        exp_qa.push_back(pack(m.acc, m.cnt, m.sat));
      end else begin
        m.grp = 1'b1;
      end
    end
    if (s != 0) mb = m;
    else        ma = m;
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle(input logic [15:0] z, input logic v, input logic last, input logic ordy);
    @(negedge clk);
    z_s = z; v_s = v; last_s = last; ordy_s = ordy;
    #1;
    check_side(0, ifa.in_ready, ifa.out_valid, 32'(ifa.acc), ifa.count, ifa.sat);
    check_side(1, ifb.in_ready, ifb.out_valid, 32'(ifb.acc), ifb.count, ifb.sat);
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_a_acc"},  64'(ifa.acc), 64'd0);
    check_val({tag, "_a_cnt"},  64'(ifa.count), 64'd0);
    check_val({tag, "_a_sat"},  64'(ifa.sat), 64'd0);
    check_val({tag, "_a_ov"},   64'(ifa.out_valid), 64'd0);
    check_val({tag, "_b_acc"},  64'(ifb.acc), 64'd0);
    check_val({tag, "_b_cnt"},  64'(ifb.count), 64'd0);
    check_val({tag, "_b_ov"},   64'(ifb.out_valid), 64'd0);
    check_val({tag, "_a_rdy"},  64'(ifa.in_ready), 64'd1);
    check_val({tag, "_b_rdy"},  64'(ifb.in_ready), 64'd1);
  endtask

  // Asynchronous pulse between edges; any open or pending group is dropped.
  task automatic reset_pulse();
    @(negedge clk);
    v_s = 1'b0; last_s = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset_vals("rst_mid");
    #1 rst_n = 1'b1;
    ma = '{default: 0};
    mb = '{default: 0};
    exp_qa.delete();
    exp_qb.delete();
  endtask

  // Close any open group on both DUTs and drain the results.
  task automatic flush();
    cycle(16'd3, 1'b1, 1'b1, 1'b1);
    repeat (3) cycle(16'd0, 1'b0, 1'b0, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] zr;
    ma = '{default: 0};
    mb = '{default: 0};
    #22;
    check_reset_vals("rst_init");
    rst_n = 1'b1;
    #1;
    check_val("a_rdy_release", 64'(ifa.in_ready), 64'd1);

    // 1,2,3,4 back to back
    cycle(16'd1, 1'b1, 1'b0, 1'b1);
    cycle(16'd2, 1'b1, 1'b0, 1'b1);
    cycle(16'd3, 1'b1, 1'b0, 1'b1);
    cycle(16'd4, 1'b1, 1'b0, 1'b1);
    cycle(16'd0, 1'b0, 1'b0, 1'b1);
    cycle(16'd0, 1'b0, 1'b0, 1'b1);
    flush();

    // early termination, then a new group
    cycle(16'd100, 1'b1, 1'b0, 1'b1);
    cycle(16'd200, 1'b1, 1'b0, 1'b1);
    cycle(16'd300, 1'b1, 1'b1, 1'b1);
    cycle(16'd77,  1'b1, 1'b0, 1'b1);
    cycle(16'd0,   1'b0, 1'b1, 1'b1);  // in_last without accept is ignored
    flush();

    // saturation, then a fresh single-product group
    repeat (3) cycle(16'hFFFF, 1'b1, 1'b0, 1'b1);
    flush();
    cycle(16'd5, 1'b1, 1'b1, 1'b1);
    repeat (2) cycle(16'd0, 1'b0, 1'b0, 1'b1);

    // backpressure: result pending, out_ready low for 5 cycles
    cycle(16'd11, 1'b1, 1'b0, 1'b1);
    cycle(16'd12, 1'b1, 1'b1, 1'b0);
    repeat (5) cycle(16'd40, 1'b1, 1'b0, 1'b0);
    cycle(16'd40, 1'b1, 1'b0, 1'b1);
    flush();

    // gapped input
    for (int i = 0; i < 8; i++) cycle(16'h8000, (i % 2) == 0, 1'b0, 1'b1);
    flush();

    // reset in the middle of a group
    cycle(16'd7, 1'b1, 1'b0, 1'b1);
    cycle(16'd9, 1'b1, 1'b0, 1'b1);
    reset_pulse();
    repeat (4) cycle(16'd1, 1'b1, 1'b0, 1'b1);
    flush();

    // random traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) zr = 16'hFFFF - 16'($urandom_range(0, 15));
      else                           zr = 16'($urandom_range(0, 65535));
      cycle(zr, $urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0, $urandom_range(0, 2) != 0);
      if (i == 200) reset_pulse();
    end
    flush();
    repeat (4) cycle(16'd0, 1'b0, 1'b0, 1'b1);
    check_val("a_q_left", 64'(exp_qa.size()), 64'd0);
    check_val("b_q_left", 64'(exp_qb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
